// File: rtl/hazard_control_pkg.sv
// hazard_control_pkg: definitions shared by the hazard-control slice.
//   - hc_state_e : hazard FSM state encoding
//   - hc_ctrl_t  : bundle of PC and pipeline-register enables/flushes
//   - NOP_INSN   : instruction a flushed pipeline register loads
package hazard_control_pkg;

  typedef enum logic [1:0] {
    HC_RUN       = 2'd0,
    HC_MEM_WAIT  = 2'd1,
    HC_LU_BUBBLE = 2'd2
  } hc_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef struct packed {
    logic pc_we;
    logic pc_redirect;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
  } hc_ctrl_t;

  // Free-running pipeline.
  localparam hc_ctrl_t CTRL_RUN = '{
    pc_we: 1'b1, pc_redirect: 1'b0, if_id_en: 1'b1, id_ex_en: 1'b1,
    ex_mem_en: 1'b1, mem_wb_en: 1'b1,
    if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_flush: 1'b0};

  // Whole pipeline frozen behind the data memory.
  localparam hc_ctrl_t CTRL_HOLD = '{
    pc_we: 1'b0, pc_redirect: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0,
    ex_mem_en: 1'b0, mem_wb_en: 1'b0,
    if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_flush: 1'b0};

  // Load-use: front end holds, a bubble goes into EX/MEM, the load drains.
  localparam hc_ctrl_t CTRL_LOAD_USE = '{
    pc_we: 1'b0, pc_redirect: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0,
    ex_mem_en: 1'b1, mem_wb_en: 1'b1,
    if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_flush: 1'b1};

  // Redirect: PC takes the target, the two wrong-path slots are squashed.
  localparam hc_ctrl_t CTRL_REDIRECT = '{
    pc_we: 1'b1, pc_redirect: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1,
    ex_mem_en: 1'b1, mem_wb_en: 1'b1,
    if_id_flush: 1'b1, id_ex_flush: 1'b1, ex_mem_flush: 1'b0};

endpackage

// File: rtl/hazard_timeout_ctr.sv
// hazard_timeout_ctr: counts consecutive data-memory wait cycles, saturating
// at MEM_TIMEOUT.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : return the count to zero (wins over inc)
//   inc       : count one more wait cycle
//   at_limit  : count has reached MEM_TIMEOUT
module hazard_timeout_ctr
  import hazard_control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(MEM_TIMEOUT);

  logic [TO_W-1:0] count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign at_limit = (count == LIMIT);

endmodule

// File: rtl/hazard_control.sv
// hazard_control: pipeline-control end of the EX forwarding path.
// Turns load-use stalls, EX redirects and MEM data-memory handshakes into
// PC / IF-ID / ID-EX / EX-MEM / MEM-WB enables and flushes.
//   inputs : clk, rst (sync, active-high), fwd_stall, ex_branch_taken,
//            ex_branch_target, mem_dmem_req, dmem_ready
//   outputs: pc_we, pc_redirect, redirect_pc, *_en, *_flush, mem_timeout
// Build option HAZARD_PERF_CNT_EN adds perf_mem_wait_cycles, perf_lu_bubbles
// and perf_redirects (32-bit wrapping counters).
module hazard_control
  import hazard_control_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fwd_stall,
  input  logic            ex_branch_taken,
  input  logic [XLEN-1:0] ex_branch_target,
  input  logic            mem_dmem_req,
  input  logic            dmem_ready,
  output logic            pc_we,
  output logic            pc_redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            if_id_en,
  output logic            id_ex_en,
  output logic            ex_mem_en,
  output logic            mem_wb_en,
  output logic            if_id_flush,
  output logic            id_ex_flush,
  output logic            ex_mem_flush,
  output logic            mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]     perf_mem_wait_cycles,
  output logic [31:0]     perf_lu_bubbles,
  output logic [31:0]     perf_redirects
`endif
);

  hc_state_e       state_q, state_d;
  hc_ctrl_t        ctrl;
  logic            pend_valid_q;
  logic [XLEN-1:0] pend_target_q;
  logic            timeout_q;
  logic            at_limit;

  logic mem_wait;
  logic lu_event;
  logic redir_ok;
  logic redir_event;
  logic take_pending;

  // Event decode shared by next-state and output logic. The cycle that leaves
  // MEM_WAIT only restarts the pipeline: the EX instruction is still the one
  // held during the wait, so its branch is already in the pending register.
  assign mem_wait     = mem_dmem_req & ~dmem_ready;
  assign lu_event     = ~mem_wait & (state_q == HC_RUN) & fwd_stall;
  assign redir_ok     = ~mem_wait & ((state_q == HC_LU_BUBBLE) ||
                                     ((state_q == HC_RUN) && !fwd_stall));
  // A deferred redirect outranks (and discards) a live one: the live branch is
  // a stale repeat of the instruction that was already latched.
  assign take_pending = redir_ok & pend_valid_q;
  assign redir_event  = redir_ok & (pend_valid_q | ex_branch_taken);

  hazard_timeout_ctr #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TO_W        (TO_W)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr      (~mem_wait),
    .inc      (mem_wait),
    .at_limit (at_limit)
  );

  // State register plus pending-redirect and sticky timeout state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HC_RUN;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_q | at_limit;
      if (mem_wait && ex_branch_taken) begin
        pend_valid_q  <= 1'b1;
        pend_target_q <= ex_branch_target;
      end else if (take_pending) begin
        pend_valid_q  <= 1'b0;
      end
    end
  end

  // Next state: LU_BUBBLE and the MEM_WAIT exit cycle both fall back to RUN.
  always_comb begin
    if (mem_wait) begin
      state_d = HC_MEM_WAIT;
    end else if (lu_event) begin
      state_d = HC_LU_BUBBLE;
    end else begin
      state_d = HC_RUN;
    end
  end

  // Outputs. Reset forces the idle values in the same cycle it is asserted.
  always_comb begin
    // NOTE: every output gets a default before the if-chain so no path leaves
    // a value unassigned and no latch is inferred.
    ctrl        = CTRL_RUN;
    redirect_pc = '0;
    if (rst) begin
      ctrl = CTRL_RUN;
    end else if (mem_wait) begin
      ctrl = CTRL_HOLD;
    end else if (lu_event) begin
      ctrl = CTRL_LOAD_USE;
    end else if (redir_event) begin
      ctrl        = CTRL_REDIRECT;
      redirect_pc = pend_valid_q ? pend_target_q : ex_branch_target;
    end
  end

  assign {pc_we, pc_redirect, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
          if_id_flush, id_ex_flush, ex_mem_flush} = ctrl;

  // Flag shows in the cycle the count reaches the limit, then sticks.
  assign mem_timeout = ~rst & (timeout_q | at_limit);

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_mem_wait_cycles <= '0;
      perf_lu_bubbles      <= '0;
      perf_redirects       <= '0;
    end else begin
      if (mem_wait)    perf_mem_wait_cycles <= perf_mem_wait_cycles + 32'd1;
      if (lu_event)    perf_lu_bubbles      <= perf_lu_bubbles + 32'd1;
      if (redir_event) perf_redirects       <= perf_redirects + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_control.sv
// tb_hazard_control: directed scenarios plus a randomized run checked against
// a cycle-level behavioural model of the hazard rules.
module tb_hazard_control;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 4;

  // {pc_we, pc_redirect, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
  //  if_id_flush, id_ex_flush, ex_mem_flush}
  localparam logic [8:0] C_RUN   = 9'b1_0_1111_000;
  localparam logic [8:0] C_HOLD  = 9'b0_0_0000_000;
  localparam logic [8:0] C_LU    = 9'b0_0_0011_001;
  localparam logic [8:0] C_REDIR = 9'b1_1_1111_110;

  logic            clk = 1'b0;
  logic            rst;
  logic            fwd_stall;
  logic            ex_branch_taken;
  logic [XLEN-1:0] ex_branch_target;
  logic            mem_dmem_req;
  logic            dmem_ready;
  logic            pc_we, pc_redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic            if_id_flush, id_ex_flush, ex_mem_flush;
  logic            mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]     perf_mem_wait_cycles, perf_lu_bubbles, perf_redirects;
`endif

  int checks = 0;
  int errors = 0;

  hazard_control #(
    .XLEN        (XLEN),
    .MEM_TIMEOUT (TIMEOUT),
    .TO_W        (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .fwd_stall        (fwd_stall),
    .ex_branch_taken  (ex_branch_taken),
    .ex_branch_target (ex_branch_target),
    .mem_dmem_req     (mem_dmem_req),
    .dmem_ready       (dmem_ready),
    .pc_we            (pc_we),
    .pc_redirect      (pc_redirect),
    .redirect_pc      (redirect_pc),
    .if_id_en         (if_id_en),
    .id_ex_en         (id_ex_en),
    .ex_mem_en        (ex_mem_en),
    .mem_wb_en        (mem_wb_en),
    .if_id_flush      (if_id_flush),
    .id_ex_flush      (id_ex_flush),
    .ex_mem_flush     (ex_mem_flush),
    .mem_timeout      (mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_mem_wait_cycles (perf_mem_wait_cycles),
    .perf_lu_bubbles      (perf_lu_bubbles),
    .perf_redirects       (perf_redirects)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] ctrl_vec();
    return {pc_we, pc_redirect, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
            if_id_flush, id_ex_flush, ex_mem_flush};
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled one
  // unit after that, well before the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fwd_stall = 1'b0; ex_branch_taken = 1'b0; ex_branch_target = '0;
    mem_dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    // Every other input active: reset must still win.
    rst = 1'b1; fwd_stall = 1'b1; ex_branch_taken = 1'b1;
    ex_branch_target = 32'hDEAD_BEEF; mem_dmem_req = 1'b1; dmem_ready = 1'b0;
    #1;
    checks++;
    if (ctrl_vec() !== C_RUN) begin
      errors++; $display("FAIL reset_ctrl got %b want %b", ctrl_vec(), C_RUN);
    end
    checks++;
    if (redirect_pc !== '0 || mem_timeout !== 1'b0) begin
      errors++; $display("FAIL reset_pc_to got %h/%b want 0/0", redirect_pc, mem_timeout);
    end
    tick();
    rst = 1'b0; idle_inputs();
    #1;
    checks++;
    if (dut.state_q !== 2'd0 || dut.pend_valid_q !== 1'b0) begin
      errors++; $display("FAIL reset_state got %0d/%b want 0/0", dut.state_q, dut.pend_valid_q);
    end
    checks++;
    if (ctrl_vec() !== C_RUN) begin
      errors++; $display("FAIL post_reset_ctrl got %b want %b", ctrl_vec(), C_RUN);
    end
  endtask

  task automatic test_load_use();
    apply_reset();
    fwd_stall = 1'b1;
    #1;
    checks++;
    if (ctrl_vec() !== C_LU) begin
      errors++; $display("FAIL lu_cycle got %b want %b", ctrl_vec(), C_LU);
    end
    tick();
    // Stall re-asserted in the bubble cycle is ignored.
    #1;
    checks++;
    if (dut.state_q !== 2'd2 || ctrl_vec() !== C_RUN) begin
      errors++; $display("FAIL lu_bubble got state %0d ctrl %b want 2 %b", dut.state_q, ctrl_vec(), C_RUN);
    end
    tick();
    fwd_stall = 1'b0;
    #1;
    checks++;
    if (dut.state_q !== 2'd0) begin
      errors++; $display("FAIL lu_return got %0d want 0", dut.state_q);
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    ex_branch_taken = 1'b1; ex_branch_target = 32'h0000_0100;
    #1;
    checks++;
    if (ctrl_vec() !== C_REDIR || redirect_pc !== 32'h100) begin
      errors++; $display("FAIL redirect got %b %h want %b 00000100", ctrl_vec(), redirect_pc, C_REDIR);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (ctrl_vec() !== C_RUN || redirect_pc !== '0) begin
      errors++; $display("FAIL redirect_after got %b %h want %b 0", ctrl_vec(), redirect_pc, C_RUN);
    end
  endtask

  task automatic test_mem_wait();
    apply_reset();
    mem_dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctrl_vec() !== C_HOLD) begin
        errors++; $display("FAIL mem_wait_%0d got %b want %b", i, ctrl_vec(), C_HOLD);
      end
      tick();
    end
    dmem_ready = 1'b1;
    #1;
    checks++;
    if (ctrl_vec() !== C_RUN || mem_timeout !== 1'b0) begin
      errors++; $display("FAIL mem_ready got %b to=%b want %b to=0", ctrl_vec(), mem_timeout, C_RUN);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (dut.state_q !== 2'd0 || mem_timeout !== 1'b0) begin
      errors++; $display("FAIL mem_after got %0d to=%b want 0 to=0", dut.state_q, mem_timeout);
    end
  endtask

  task automatic test_deferred_redirect();
    apply_reset();
    mem_dmem_req = 1'b1; dmem_ready = 1'b0;
    ex_branch_taken = 1'b1; ex_branch_target = 32'h0000_0200;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (ctrl_vec() !== C_HOLD) begin
        errors++; $display("FAIL defer_wait_%0d got %b want %b", i, ctrl_vec(), C_HOLD);
      end
      tick();
      ex_branch_taken = 1'b0;
    end
    dmem_ready = 1'b1;
    #1;
    checks++;
    if (pc_redirect !== 1'b0) begin
      errors++; $display("FAIL defer_exit got %b want 0", pc_redirect);
    end
    tick();
    // Stale duplicate with a different target must not win over the pending.
    idle_inputs();
    ex_branch_taken = 1'b1; ex_branch_target = 32'h0000_0999;
    #1;
    checks++;
    if (ctrl_vec() !== C_REDIR || redirect_pc !== 32'h200) begin
      errors++; $display("FAIL defer_apply got %b %h want %b 00000200", ctrl_vec(), redirect_pc, C_REDIR);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (pc_redirect !== 1'b0 || dut.pend_valid_q !== 1'b0) begin
      errors++; $display("FAIL defer_clear got %b/%b want 0/0", pc_redirect, dut.pend_valid_q);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    mem_dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (mem_timeout !== (i >= TIMEOUT) || ctrl_vec() !== C_HOLD) begin
        errors++; $display("FAIL timeout_%0d got to=%b ctrl=%b want to=%b ctrl=%b",
                           i, mem_timeout, ctrl_vec(), (i >= TIMEOUT), C_HOLD);
      end
      tick();
    end
    dmem_ready = 1'b1;
    tick();
    // Back in RUN, enter a fresh wait: flag must still be set.
    dmem_ready = 1'b0;
    #1;
    checks++;
    if (mem_timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_sticky got %b want 1", mem_timeout);
    end
    tick();
    // Reset while sitting in MEM_WAIT with the request still pending.
    rst = 1'b1;
    #1;
    checks++;
    if (mem_timeout !== 1'b0 || ctrl_vec() !== C_RUN) begin
      errors++; $display("FAIL timeout_rst got to=%b ctrl=%b want 0 %b", mem_timeout, ctrl_vec(), C_RUN);
    end
    tick();
    rst = 1'b0; idle_inputs();
    #1;
    checks++;
    if (mem_timeout !== 1'b0 || dut.state_q !== 2'd0 || ctrl_vec() !== C_RUN) begin
      errors++; $display("FAIL timeout_clear got to=%b state=%0d ctrl=%b want 0 0 %b",
                         mem_timeout, dut.state_q, ctrl_vec(), C_RUN);
    end
  endtask

  task automatic test_lu_with_branch();
    apply_reset();
    fwd_stall = 1'b1; ex_branch_taken = 1'b1; ex_branch_target = 32'h0000_0300;
    #1;
    checks++;
    if (ctrl_vec() !== C_LU || redirect_pc !== '0) begin
      errors++; $display("FAIL lu_branch got %b %h want %b 0", ctrl_vec(), redirect_pc, C_LU);
    end
    tick();
    idle_inputs();
    #1;
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (perf_lu_bubbles !== 32'd1 || perf_redirects !== 32'd0) begin
      errors++; $display("FAIL lu_branch_perf got %0d/%0d want 1/0", perf_lu_bubbles, perf_redirects);
    end
`endif
    tick();
  endtask

  // Randomized run against a model of the hazard rules: one flag for "the
  // pipeline is blocked on memory", one for "the previous cycle was a
  // load-use bubble", and a one-deep queue of deferred redirect targets.
  task automatic test_random();
    logic [8:0]      exp_ctrl;
    logic [XLEN-1:0] exp_pc;
    logic            exp_to, waiting;
    logic            m_in_wait, m_bubble, m_sticky;
    int              m_wcount, n_wait, n_lu, n_redir;
    logic [XLEN-1:0] pend[$];
    apply_reset();
    m_in_wait = 0; m_bubble = 0; m_sticky = 0; m_wcount = 0;
    n_wait = 0; n_lu = 0; n_redir = 0; pend.delete();
    for (int i = 0; i < 600; i++) begin
      rst              = ($urandom_range(99) == 0);
      mem_dmem_req     = ($urandom_range(99) < 35);
      dmem_ready       = ($urandom_range(2) == 0);
      fwd_stall        = ($urandom_range(3) == 0);
      ex_branch_taken  = ($urandom_range(2) == 0);
      ex_branch_target = $urandom;
      #1;
      waiting = mem_dmem_req && !dmem_ready;
      exp_pc  = '0;
      exp_to  = !rst && (m_sticky || m_wcount >= TIMEOUT);
      if (rst)                                exp_ctrl = C_RUN;
      else if (waiting)                       exp_ctrl = C_HOLD;
      else if (m_in_wait)                     exp_ctrl = C_RUN;
      else if (!m_bubble && fwd_stall)        exp_ctrl = C_LU;
      else if (pend.size() > 0 || ex_branch_taken) begin
        exp_ctrl = C_REDIR;
        exp_pc   = (pend.size() > 0) ? pend[0] : ex_branch_target;
      end else                                exp_ctrl = C_RUN;

      checks++;
      if (ctrl_vec() !== exp_ctrl) begin
        errors++; $display("FAIL rand_ctrl[%0d] got %b want %b", i, ctrl_vec(), exp_ctrl);
      end
      checks++;
      if (redirect_pc !== exp_pc) begin
        errors++; $display("FAIL rand_pc[%0d] got %h want %h", i, redirect_pc, exp_pc);
      end
      checks++;
      if (mem_timeout !== exp_to) begin
        errors++; $display("FAIL rand_timeout[%0d] got %b want %b", i, mem_timeout, exp_to);
      end

      if (rst) begin
        m_in_wait = 0; m_bubble = 0; m_sticky = 0; m_wcount = 0;
        n_wait = 0; n_lu = 0; n_redir = 0; pend.delete();
      end else begin
        m_sticky = m_sticky || (m_wcount >= TIMEOUT);
        if (waiting) begin
          if (ex_branch_taken) pend = '{ex_branch_target};
          if (m_wcount < TIMEOUT) m_wcount++;
          m_in_wait = 1; m_bubble = 0; n_wait++;
        end else begin
          m_wcount = 0;
          if (m_in_wait) begin
            m_in_wait = 0; m_bubble = 0;
          end else if (!m_bubble && fwd_stall) begin
            m_bubble = 1; n_lu++;
          end else begin
            if (exp_ctrl == C_REDIR) begin
              n_redir++;
              if (pend.size() > 0) pend.delete();
            end
            m_bubble = 0;
          end
        end
      end
      tick();
    end
    rst = 1'b0; idle_inputs();
`ifdef HAZARD_PERF_CNT_EN
    #1;
    checks++;
    if (perf_mem_wait_cycles !== 32'(n_wait) || perf_lu_bubbles !== 32'(n_lu) ||
        perf_redirects !== 32'(n_redir)) begin
      errors++; $display("FAIL rand_perf got %0d/%0d/%0d want %0d/%0d/%0d",
                         perf_mem_wait_cycles, perf_lu_bubbles, perf_redirects, n_wait, n_lu, n_redir);
    end
`endif
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_deferred_redirect();
    test_timeout();
    test_lu_with_branch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_control.md
Name: hazard_control

Overview:
- Pipeline-control end of the EX-stage forwarding path: consumes the forwarding unit's load-use stall plus EX branch redirects and MEM-stage data-memory handshakes.
- Drives enable/flush for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Sequences bubbles, memory waits and deferred redirects through a small FSM, and flags data-memory timeouts.

Parameters:
- XLEN, 32, PC/target width
- MEM_TIMEOUT, 255, max MEM_WAIT cycles before the timeout flag sets
- TO_W, 8, timeout counter width; must satisfy 2^TO_W > MEM_TIMEOUT

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- fwd_stall  in  1  load-use stall request from forwarding unit (load in MEM feeds EX source)
- ex_branch_taken  in  1  EX resolves a taken branch/jump this cycle
- ex_branch_target  in  XLEN  redirect target, valid with ex_branch_taken
- mem_dmem_req  in  1  MEM stage holds a load/store needing the data memory
- dmem_ready  in  1  data memory completes the MEM-stage access this cycle
- pc_we  out  1  PC register write enable
- pc_redirect  out  1  PC loads redirect_pc instead of PC+4
- redirect_pc  out  XLEN  redirect target
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register enables
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  insert NOP (synchronous clear) at that register
- mem_timeout  out  1  sticky error flag

Behaviour:
- States: RUN, MEM_WAIT, LU_BUBBLE. Reset: state=RUN, all enables 1, flushes 0, pc_redirect=0, redirect_pc=0, mem_timeout=0, timeout counter=0, pending-redirect register cleared. Reset wins over every other input in the same cycle, including mid-MEM_WAIT.
- Outputs are combinational from state and inputs. Zero added latency; the redirect takes effect at the next clock edge.
- Priority each cycle:
  1. Memory wait: mem_dmem_req & !dmem_ready.
  2. Load-use: fwd_stall.
  3. Redirect: ex_branch_taken.
- Memory wait:
  - All enables 0, all flushes 0.
  - Go to MEM_WAIT and increment the counter.
  - A coincident ex_branch_taken is latched into the pending register (target + valid). It is not applied.
- MEM_WAIT:
  - Hold all enables 0 until dmem_ready; then return to RUN and clear the counter.
  - The counter saturates. It sets mem_timeout when the count reaches MEM_TIMEOUT.
  - mem_timeout clears only on rst.
- Load-use in RUN:
  - pc_we=0, if_id_en=0, id_ex_en=0, ex_mem_flush=1, mem_wb_en=1.
  - Go to LU_BUBBLE.
  - A coincident ex_branch_taken is ignored. It belongs to the stalled instruction, which re-executes.
- LU_BUBBLE:
  - Exactly one cycle. Normal enables apply and fwd_stall is ignored.
  - A re-asserted fwd_stall here is a protocol error; the state still returns to RUN.
  - Redirects in this cycle are processed normally.
- Redirect (RUN or LU_BUBBLE, no higher-priority event):
  - pc_we=1, pc_redirect=1, redirect_pc=ex_branch_target.
  - if_id_flush=1, id_ex_flush=1; other enables 1.
- Pending redirect: on the first cycle after leaving MEM_WAIT, the pending redirect is applied exactly as a redirect, then cleared.
  - A live ex_branch_taken in that cycle is a stale duplicate of the same EX instruction and is ignored.
- Flush beats enable: a flushed register loads NOP even if its enable is 1.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, adds three 32-bit wrapping output counters, cleared on rst:
  - perf_mem_wait_cycles: cycles spent in MEM_WAIT, including the entry cycle.
  - perf_lu_bubbles: count of load-use events.
  - perf_redirects: count of redirects, including deferred ones.
- When undefined, these ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Shared package/include gets:
  - state encoding constants: HC_RUN=2'd0, HC_MEM_WAIT=2'd1, HC_LU_BUBBLE=2'd2.
  - NOP instruction constant (32'h00000013), used by the pipeline registers on flush.
- One natural sub-module, hazard_timeout_ctr: a saturating counter with clear, increment and a compare-to-MEM_TIMEOUT flag output.
- The FSM and output decode stay in the top module.

Test Plan:
- fwd_stall=1 one cycle in RUN -> that cycle: pc_we=0, if_id_en=0, id_ex_en=0, ex_mem_flush=1, mem_wb_en=1; next cycle: state LU_BUBBLE, all enables 1; then RUN.
- ex_branch_taken=1, target=32'h0000_0100 in RUN -> same cycle: pc_redirect=1, redirect_pc=32'h100, if_id_flush=id_ex_flush=1.
- mem_dmem_req=1, dmem_ready=0 for 3 cycles, then dmem_ready=1 -> all enables 0 for 3 cycles; RUN with enables 1 on the ready cycle's edge; mem_timeout stays 0.
- mem_dmem_req=1 with ex_branch_taken=1, target=32'h0000_0200, ready after 2 cycles -> no redirect during the wait; first RUN cycle: pc_redirect=1, redirect_pc=32'h200; pending register cleared after.
- MEM_TIMEOUT=4, dmem_ready held 0 for 10 cycles -> mem_timeout=1 once the count reaches 4 and stays 1 after ready; rst=1 for one cycle clears it and forces all reset values.
- fwd_stall and ex_branch_taken asserted together -> load-use handling only, no redirect; with HAZARD_PERF_CNT_EN defined, perf_lu_bubbles=1 and perf_redirects=0.
